// File: rtl/wb_pipe_if.sv
// Bundle between decode/EX/MEM control and the destination-register pipeline.
// master drives the ID fields and stage data; slave is the pipeline itself.
interface wb_pipe_if #(
  parameter int CNT_W = 16
);
  logic             id_do_reg_write;
  logic [4:0]       id_write_reg_addr;
  logic [1:0]       id_select_write_reg;
  logic             id_do_dm_read;
  logic [31:0]      id_imm_extend;
  logic [31:0]      alu_result;
  logic [31:0]      dm_read_data;
  logic             do_hazard;
  logic             flush;
  logic             pipe_stall;

  logic             xREG2_do_reg_write;
  logic [4:0]       xREG2_write_reg_addr;
  logic [1:0]       xREG2_select_write_reg;
  logic             xREG2_do_dm_read;
  logic [31:0]      xREG2_imm_extend;
  logic             xREG3_do_reg_write;
  logic [4:0]       xREG3_write_reg_addr;
  logic [31:0]      write_reg_data;
  logic             xREG4_do_reg_write;
  logic [4:0]       xREG4_write_reg_addr;
  logic [31:0]      xREG4_write_reg_data;
  logic             hazard_stall;
  logic [CNT_W-1:0] hazard_count;

  modport master (
    output id_do_reg_write, id_write_reg_addr, id_select_write_reg, id_do_dm_read,
           id_imm_extend, alu_result, dm_read_data, do_hazard, flush, pipe_stall,
    input  xREG2_do_reg_write, xREG2_write_reg_addr, xREG2_select_write_reg,
           xREG2_do_dm_read, xREG2_imm_extend, xREG3_do_reg_write, xREG3_write_reg_addr,
           write_reg_data, xREG4_do_reg_write, xREG4_write_reg_addr, xREG4_write_reg_data,
           hazard_stall, hazard_count
  );

  modport slave (
    input  id_do_reg_write, id_write_reg_addr, id_select_write_reg, id_do_dm_read,
           id_imm_extend, alu_result, dm_read_data, do_hazard, flush, pipe_stall,
    output xREG2_do_reg_write, xREG2_write_reg_addr, xREG2_select_write_reg,
           xREG2_do_dm_read, xREG2_imm_extend, xREG3_do_reg_write, xREG3_write_reg_addr,
           write_reg_data, xREG4_do_reg_write, xREG4_write_reg_addr, xREG4_write_reg_data,
           hazard_stall, hazard_count
  );
endinterface

// File: rtl/wb_pipe.sv
// Destination-register pipeline EX/MEM/WB: one stage per edge, bubbles on hazard/flush,
// whole-pipe freeze on pipe_stall, saturating count of load-use bubble cycles.
module wb_pipe #(
  parameter int CNT_W = 16
) (
  input logic       clock,
  input logic       reset,
  wb_pipe_if.slave  bus
);

  localparam logic [1:0] WRREG_ALURESULT = 2'b00;
  localparam logic [1:0] WRREG_IMMDATA   = 2'b01;
  localparam logic [1:0] WRREG_MEMDATA   = 2'b10;
  localparam logic [1:0] WRREG_RESERVED  = 2'b11;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [1:0]  sel;
    logic        rd;
    logic [31:0] imm;
  } ex_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] imm;
  } mem_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  ex_t              x2_q, x2_d;
  mem_t             x3_q, x3_d;
  wb_t              x4_q, x4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wr_data;
  logic             hz_stall;

  // The global freeze already holds the front end, so no separate hazard hold then.
  assign hz_stall = bus.do_hazard & ~bus.flush & ~bus.pipe_stall;

  always_comb begin
    wr_data = '0;
    case (x3_q.sel)
      WRREG_ALURESULT: wr_data = x3_q.alu;
      WRREG_IMMDATA:   wr_data = x3_q.imm;
      WRREG_MEMDATA:   wr_data = bus.dm_read_data;
      default:         wr_data = '0;
    endcase
  end

  always_comb begin
    x2_d  = x2_q;
    x3_d  = x3_q;
    x4_d  = x4_q;
    cnt_d = cnt_q;
    if (!bus.pipe_stall) begin
      if (bus.flush || bus.do_hazard) begin
        x2_d = '0;
      end else begin
        x2_d.wr   = bus.id_do_reg_write & (bus.id_select_write_reg != WRREG_RESERVED);
        x2_d.addr = bus.id_write_reg_addr;
        x2_d.sel  = bus.id_select_write_reg;
        x2_d.rd   = bus.id_do_dm_read;
        x2_d.imm  = bus.id_imm_extend;
      end

      x3_d.wr   = x2_q.wr;
      x3_d.addr = x2_q.addr;
      x3_d.sel  = x2_q.sel;
      x3_d.alu  = bus.alu_result;
      x3_d.imm  = x2_q.imm;

      x4_d.wr   = x3_q.wr;
      x4_d.addr = x3_q.addr;
      x4_d.data = wr_data;

      if (hz_stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x2_q  <= '0;
      x3_q  <= '0;
      x4_q  <= '0;
      cnt_q <= '0;
    end else begin
      x2_q  <= x2_d;
      x3_q  <= x3_d;
      x4_q  <= x4_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.xREG2_do_reg_write     = x2_q.wr;
  assign bus.xREG2_write_reg_addr   = x2_q.addr;
  assign bus.xREG2_select_write_reg = x2_q.sel;
  assign bus.xREG2_do_dm_read       = x2_q.rd;
  assign bus.xREG2_imm_extend       = x2_q.imm;
  assign bus.xREG3_do_reg_write     = x3_q.wr;
  assign bus.xREG3_write_reg_addr   = x3_q.addr;
  assign bus.write_reg_data         = wr_data;
  assign bus.xREG4_do_reg_write     = x4_q.wr;
  assign bus.xREG4_write_reg_addr   = x4_q.addr;
  assign bus.xREG4_write_reg_data   = x4_q.data;
  assign bus.hazard_stall           = hz_stall;
  assign bus.hazard_count           = cnt_q;

endmodule

// File: tb/tb_wb_pipe.sv
// Directed bench for wb_pipe: write-backs go through a scoreboard queue checked by a monitor;
// stage/bubble/counter values are checked directly against hand-computed constants.
module tb_wb_pipe;
  localparam int CNT_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbx_t;

  wbx_t sb_q[$];

  wb_pipe_if #(.CNT_W(CNT_W)) bus ();

  wb_pipe #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic wr, input logic [4:0] addr, input logic [1:0] sel,
                        input logic rd, input logic [31:0] imm);
    bus.id_do_reg_write     = wr;
    bus.id_write_reg_addr   = addr;
    bus.id_select_write_reg = sel;
    bus.id_do_dm_read       = rd;
    bus.id_imm_extend       = imm;
  endtask

  task automatic push(input logic [4:0] addr, input logic [31:0] data);
    wbx_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: a write-back is presented when xREG4 holds a writing instruction after an advancing edge.
  initial begin
    logic adv;
    wbx_t e;
    forever begin
      @(posedge clock);
      adv = !reset && !bus.pipe_stall;
      @(negedge clock);
      if (adv && bus.xREG4_do_reg_write === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL wb_unexpected: got r%0d=%h expected none", bus.xREG4_write_reg_addr,
                   bus.xREG4_write_reg_data);
        end else begin
          e = sb_q.pop_front();
          chk("wb_addr", {27'd0, bus.xREG4_write_reg_addr}, {27'd0, e.addr});
          chk("wb_data", bus.xREG4_write_reg_data, e.data);
        end
      end
    end
  end

  initial begin
    // Reset with every input driven nonzero.
    set_id(1'b1, 5'd31, 2'b01, 1'b1, 32'hFFFF_FFFF);
    bus.alu_result   = 32'hA5A5_A5A5;
    bus.dm_read_data = 32'h5A5A_5A5A;
    bus.do_hazard    = 1'b1;
    bus.flush        = 1'b1;
    bus.pipe_stall   = 1'b1;
    reset            = 1'b1;
    tick();
    chk("rst_x2_wr",   {31'd0, bus.xREG2_do_reg_write}, 32'd0);
    chk("rst_x2_addr", {27'd0, bus.xREG2_write_reg_addr}, 32'd0);
    chk("rst_x2_sel",  {30'd0, bus.xREG2_select_write_reg}, 32'd0);
    chk("rst_x2_rd",   {31'd0, bus.xREG2_do_dm_read}, 32'd0);
    chk("rst_x2_imm",  bus.xREG2_imm_extend, 32'd0);
    chk("rst_x3_wr",   {31'd0, bus.xREG3_do_reg_write}, 32'd0);
    chk("rst_x3_addr", {27'd0, bus.xREG3_write_reg_addr}, 32'd0);
    chk("rst_wrdata",  bus.write_reg_data, 32'd0);
    chk("rst_x4_wr",   {31'd0, bus.xREG4_do_reg_write}, 32'd0);
    chk("rst_x4_addr", {27'd0, bus.xREG4_write_reg_addr}, 32'd0);
    chk("rst_x4_data", bus.xREG4_write_reg_data, 32'd0);
    chk("rst_count",   {28'd0, bus.hazard_count}, 32'd0);
    reset = 1'b0;
    set_id(1'b0, 5'd0, 2'b00, 1'b0, 32'd0);
    bus.alu_result   = 32'd0;
    bus.dm_read_data = 32'd0;
    bus.do_hazard    = 1'b0;
    bus.flush        = 1'b0;
    bus.pipe_stall   = 1'b0;
    tick();

    // ALU flow: r5 <= 0x1234.
    set_id(1'b1, 5'd5, 2'b00, 1'b0, 32'd0);
    push(5'd5, 32'h1234);
    tick();
    chk("alu_x2_wr",   {31'd0, bus.xREG2_do_reg_write}, 32'd1);
    chk("alu_x2_addr", {27'd0, bus.xREG2_write_reg_addr}, 32'd5);
    set_id(1'b0, 5'd0, 2'b00, 1'b0, 32'd0);
    bus.alu_result = 32'h1234;
    tick();
    chk("alu_x3_addr", {27'd0, bus.xREG3_write_reg_addr}, 32'd5);
    chk("alu_wrdata",  bus.write_reg_data, 32'h1234);
    bus.alu_result = 32'd0;
    tick();
    chk("alu_x4_wr",   {31'd0, bus.xREG4_do_reg_write}, 32'd1);
    chk("alu_x4_data", bus.xREG4_write_reg_data, 32'h1234);
    tick();

    // Load-use: load r3, dependent r4 held one cycle behind a single bubble.
    set_id(1'b1, 5'd3, 2'b10, 1'b1, 32'd0);
    push(5'd3, 32'hCAFE);
    tick();
    chk("ld_x2_rd", {31'd0, bus.xREG2_do_dm_read}, 32'd1);
    set_id(1'b1, 5'd4, 2'b00, 1'b0, 32'd0);
    bus.do_hazard = 1'b1;
    #1;
    chk("ld_hstall_on", {31'd0, bus.hazard_stall}, 32'd1);
    tick();
    chk("ld_bubble_wr", {31'd0, bus.xREG2_do_reg_write}, 32'd0);
    chk("ld_x3_addr",   {27'd0, bus.xREG3_write_reg_addr}, 32'd3);
    chk("ld_count",     {28'd0, bus.hazard_count}, 32'd1);
    bus.do_hazard    = 1'b0;
    bus.dm_read_data = 32'hCAFE;
    push(5'd4, 32'h55);
    #1;
    chk("ld_hstall_off", {31'd0, bus.hazard_stall}, 32'd0);
    chk("ld_wrdata",     bus.write_reg_data, 32'hCAFE);
    tick();
    chk("ld_dep_x2", {27'd0, bus.xREG2_write_reg_addr}, 32'd4);
    set_id(1'b0, 5'd0, 2'b00, 1'b0, 32'd0);
    bus.dm_read_data = 32'd0;
    bus.alu_result   = 32'h55;
    tick();
    bus.alu_result = 32'd0;
    repeat (3) tick();

    // Flush and hazard together: flush wins.
    set_id(1'b1, 5'd9, 2'b00, 1'b0, 32'h77);
    bus.do_hazard = 1'b1;
    bus.flush     = 1'b1;
    #1;
    chk("fh_hstall", {31'd0, bus.hazard_stall}, 32'd0);
    tick();
    chk("fh_x2_wr",   {31'd0, bus.xREG2_do_reg_write}, 32'd0);
    chk("fh_x2_addr", {27'd0, bus.xREG2_write_reg_addr}, 32'd0);
    chk("fh_x2_imm",  bus.xREG2_imm_extend, 32'd0);
    chk("fh_count",   {28'd0, bus.hazard_count}, 32'd1);
    bus.do_hazard = 1'b0;
    bus.flush     = 1'b0;
    set_id(1'b0, 5'd0, 2'b00, 1'b0, 32'd0);
    repeat (3) tick();

    // Stream of immediates with a 3-cycle freeze (hazard raised during it).
    set_id(1'b1, 5'd10, 2'b01, 1'b0, 32'hAAAA_0001); push(5'd10, 32'hAAAA_0001); tick();
    set_id(1'b1, 5'd11, 2'b01, 1'b0, 32'hBBBB_0002); push(5'd11, 32'hBBBB_0002); tick();
    set_id(1'b1, 5'd12, 2'b01, 1'b0, 32'hCCCC_0003); push(5'd12, 32'hCCCC_0003); tick();
    set_id(1'b1, 5'd13, 2'b01, 1'b0, 32'hDDDD_0004); push(5'd13, 32'hDDDD_0004);
    bus.pipe_stall = 1'b1;
    bus.do_hazard  = 1'b1;
    #1;
    chk("st_hstall", {31'd0, bus.hazard_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_x2_addr", {27'd0, bus.xREG2_write_reg_addr}, 32'd12);
      chk("st_x2_imm",  bus.xREG2_imm_extend, 32'hCCCC_0003);
      chk("st_x3_addr", {27'd0, bus.xREG3_write_reg_addr}, 32'd11);
      chk("st_x4_addr", {27'd0, bus.xREG4_write_reg_addr}, 32'd10);
      chk("st_x4_data", bus.xREG4_write_reg_data, 32'hAAAA_0001);
      chk("st_count",   {28'd0, bus.hazard_count}, 32'd1);
    end
    bus.pipe_stall = 1'b0;
    bus.do_hazard  = 1'b0;
    tick();
    chk("st_resume_x2", {27'd0, bus.xREG2_write_reg_addr}, 32'd13);
    set_id(1'b0, 5'd0, 2'b00, 1'b0, 32'd0);
    repeat (4) tick();

    // Reserved select never writes; its MEM result is zero.
    set_id(1'b1, 5'd14, 2'b11, 1'b0, 32'h1111);
    tick();
    chk("rsv_x2_wr",  {31'd0, bus.xREG2_do_reg_write}, 32'd0);
    chk("rsv_x2_sel", {30'd0, bus.xREG2_select_write_reg}, 32'd3);
    set_id(1'b0, 5'd0, 2'b00, 1'b0, 32'd0);
    bus.alu_result = 32'h999;
    tick();
    chk("rsv_wrdata", bus.write_reg_data, 32'd0);
    bus.alu_result = 32'd0;
    repeat (3) tick();

    // Saturation: 20 more hazard cycles on top of the existing count of 1.
    bus.do_hazard = 1'b1;
    repeat (5) tick();
    chk("sat_count_mid", {28'd0, bus.hazard_count}, 32'd6);
    repeat (15) tick();
    chk("sat_count_max", {28'd0, bus.hazard_count}, 32'hF);
    bus.do_hazard = 1'b0;
    repeat (4) tick();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_pipe.md
# wb_pipe

Destination-register pipeline for the TiniSOC core: carries each instruction's write-back control and data from decode through EX (xREG2), MEM (xREG3) and WB (xREG4), and produces every producer-side signal the `forward` unit consumes. It also inserts load-use bubbles on `do_hazard`, squashes on branch flush, freezes on a global memory stall and counts hazard stalls. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers, and its outputs drive both the register-file write port and `forward`.

## Interface
- `CNT_W`, default 16: width of the hazard stall counter.
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `id_do_reg_write`, input, 1: the decoded instruction writes a register.
- `id_write_reg_addr`, input, 5: destination register.
- `id_select_write_reg`, input, 2: write-back source. Encodings are the `def_muxs.v` values: `WRREG_ALURESULT`=2'b00, `WRREG_IMMDATA`=2'b01, `WRREG_MEMDATA`=2'b10; 2'b11 is reserved.
- `id_do_dm_read`, input, 1: the instruction is a load.
- `id_imm_extend`, input, 32: extended immediate.
- `alu_result`, input, 32: EX-stage ALU output, computed combinationally from xREG2 operands.
- `dm_read_data`, input, 32: MEM-stage data-memory read data.
- `do_hazard`, input, 1: load-use hazard flag from `forward`.
- `flush`, input, 1: branch taken; squash the instruction in ID.
- `pipe_stall`, input, 1: global freeze, e.g. a memory wait.
- `xREG2_do_reg_write`, `xREG2_write_reg_addr[4:0]`, `xREG2_select_write_reg[1:0]`, `xREG2_do_dm_read`, `xREG2_imm_extend[31:0]`, output: EX-stage registers.
- `xREG3_do_reg_write`, `xREG3_write_reg_addr[4:0]`, output: MEM-stage registers.
- `write_reg_data`, output, 32: combinational MEM-stage result.
- `xREG4_do_reg_write`, `xREG4_write_reg_addr[4:0]`, `xREG4_write_reg_data[31:0]`, output: WB-stage registers; these also drive the register-file write port.
- `hazard_stall`, output, 1: combinational hold request to PC and IF/ID; equals `do_hazard & ~flush & ~pipe_stall`.
- `hazard_count`, output, `CNT_W`: saturating count of bubble cycles.

## Operation
- Internal MEM-stage registers, not exported: `xREG3_select_write_reg`, `xREG3_alu_result`, `xREG3_imm_extend`.
- Priority at each clock edge: `reset` > `pipe_stall` > `flush` > `do_hazard` > normal advance.
- **reset**: clear every register. All `do_*` bits become 0, all addresses 0, all data 0, and `hazard_count` becomes 0.
- **pipe_stall**: all stages and `hazard_count` hold. `hazard_stall`=0 because the global stall already holds the front end.
- **flush**: xREG2 loads a bubble: `do_reg_write`=0, `do_dm_read`=0, `select`=00, addr=0, imm=0. xREG3 and xREG4 advance normally.
- **do_hazard**, no flush: xREG2 loads a bubble; xREG3 and xREG4 advance; `hazard_count` += 1, saturating at all-ones.
- **Normal advance**:
  - ID→xREG2 captures the `id_*` fields. If `id_select_write_reg`==2'b11, `xREG2_do_reg_write` is forced to 0.
  - xREG2→xREG3 captures `do_reg_write`, addr, select, `alu_result` and imm.
  - xREG3→xREG4 captures `do_reg_write`, addr and `write_reg_data`.
- `write_reg_data` mux on `xREG3_select_write_reg`:
  - 00 → `xREG3_alu_result`
  - 01 → `xREG3_imm_extend`
  - 10 → `dm_read_data`
  - 11 → 0
- Register 0 has no special handling; suppressing writes to r0 is the decoder's job.

## Timing
- Latency: the ID inputs at edge N appear on xREG2 after edge N, on xREG3 after N+1, and on xREG4 after N+2.
- `write_reg_data` is valid in the cycle the instruction occupies xREG3. `dm_read_data` must be valid in that same cycle.
- A load followed immediately by a dependent instruction:
  - `do_hazard`=1 for exactly one cycle and exactly one bubble enters xREG2.
  - The dependent instruction is held in ID and enters xREG2 on the following edge.
  - By then the load is in xREG3, so `forward` takes its MEM data via `write_reg_data`.
- `flush` and `do_hazard` in the same cycle: flush wins, a single bubble is inserted, the count is unchanged and `hazard_stall`=0.
- `pipe_stall` during a hazard cycle: nothing moves and the count is unchanged; the hazard re-evaluates on the next unstalled cycle.
- Reset mid-operation clears all in-flight instructions on that edge; no write-back of partial state occurs.

## Test plan
- **Reset**: assert `reset` with all inputs nonzero for 1 cycle → every output 0 and `hazard_count`=0 on the next cycle.
- **ALU flow**: ID presents addr=5, sel=00, wr=1 at edge 0; `alu_result`=32'h1234 during the next cycle → `xREG3_write_reg_addr`=5 after edge 1; `xREG4_write_reg_data`=32'h1234 and `xREG4_do_reg_write`=1 after edge 2.
- **Load-use**: a load to r3 (sel=10, dm_read=1) with `dm_read_data`=32'hCAFE in its MEM cycle, plus `do_hazard`=1 for one cycle → `hazard_stall`=1 that cycle; bubble in xREG2 (`xREG2_do_reg_write`=0); `write_reg_data`=32'hCAFE; `hazard_count`=1.
- **Flush plus hazard together** → one bubble, `hazard_count` unchanged, `hazard_stall`=0.
- **pipe_stall held 3 cycles mid-stream** → all xREG2/3/4 outputs constant throughout; the stream resumes unchanged afterward.
- **Reserved select and saturation**: sel=11 with wr=1 → `xREG2_do_reg_write`=0. With `CNT_W`=4, 20 hazard cycles → `hazard_count`=4'hF.
